alu_op_sequencer: RTL

Multi-cycle ALU controller that accepts one operation at a time and sequences the team's 8-bit signed adder and subtractor. ADD and SUB complete in a single execute cycle. MUL is a radix-2 Booth signed 8x8 multiply that reuses the same adder and subtractor over 8 iterations. The block sits between the instruction/operand source and the result consumer, with a start/busy/done handshake.

---
 rtl/alu_op_sequencer.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/alu_op_sequencer.sv
// Start/busy/done ALU sequencer: ADD/SUB in one execute cycle, signed Booth MUL over ITER cycles.
// Latency: done two edges after start is sampled (ADD/SUB), ITER+1 edges (MUL); start is ignored while busy.

module adder #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum,
    output logic         cout
);
    assign {cout, sum} = {1'b0, a} + {1'b0, b};
endmodule

module subtractor #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] diff,
    output logic         cout
);
    // cout=1 means no borrow
    assign {cout, diff} = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
endmodule

module alu_op_sequencer #(
    parameter int WIDTH = 8,
    parameter int ITER  = WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [1:0]         op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] result,
    output logic               cout,
    output logic               ovf
);
    localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;

    typedef enum logic [1:0] {IDLE, EXEC, MUL, DONE} state_t;

    state_t             r_state, w_next;
    logic [1:0]         r_op;
    logic [WIDTH-1:0]   r_m, r_b, r_acc, r_q;
    logic               r_qm1;
    logic [CW-1:0]      r_cnt;

    logic [WIDTH-1:0]   w_x, w_y, w_sum, w_diff;
    logic               w_add_c, w_sub_c, w_add_ovf, w_sub_ovf;
    logic [WIDTH-1:0]   w_booth_a, w_acc_nxt, w_q_nxt;
    logic               w_booth_v, w_sgn, w_last;

    // Shared arithmetic: operands in EXEC, accumulator and multiplicand in MUL
    assign w_x = (r_state == MUL) ? r_acc : r_m;
    assign w_y = (r_state == MUL) ? r_m   : r_b;

    adder #(.W(WIDTH)) u_add (.a(w_x), .b(w_y), .sum(w_sum), .cout(w_add_c));
    subtractor #(.W(WIDTH)) u_sub (.a(w_x), .b(w_y), .diff(w_diff), .cout(w_sub_c));

    assign w_add_ovf = (w_x[WIDTH-1] == w_y[WIDTH-1]) && (w_sum[WIDTH-1]  != w_x[WIDTH-1]);
    assign w_sub_ovf = (w_x[WIDTH-1] != w_y[WIDTH-1]) && (w_diff[WIDTH-1] != w_x[WIDTH-1]);

    // The true sign of A' survives overflow (M=-128), so the shift-in uses it
    always_comb begin
        w_booth_a = r_acc;
        w_booth_v = 1'b0;
        case ({r_q[0], r_qm1})
            2'b10: begin
                w_booth_a = w_diff;
                w_booth_v = w_sub_ovf;
            end
            2'b01: begin
                w_booth_a = w_sum;
                w_booth_v = w_add_ovf;
            end
            default: ;
        endcase
        w_sgn     = w_booth_a[WIDTH-1] ^ w_booth_v;
        w_acc_nxt = {w_sgn, w_booth_a[WIDTH-1:1]};
        w_q_nxt   = {w_booth_a[0], r_q[WIDTH-1:1]};
    end

    assign w_last = (r_cnt == CW'(ITER - 1));

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        busy   = (r_state != IDLE);
        done   = (r_state == DONE);
        case (r_state)
            IDLE: if (start) w_next = (op == 2'b10) ? MUL : EXEC;
            EXEC: w_next = DONE;
            MUL:  if (w_last) w_next = DONE;
            DONE: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_op   <= '0;
            r_m    <= '0;
            r_b    <= '0;
            r_acc  <= '0;
            r_q    <= '0;
            r_qm1  <= 1'b0;
            r_cnt  <= '0;
            result <= '0;
            cout   <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (start) begin
                    r_op  <= op;
                    r_m   <= a;
                    r_b   <= b;
                    r_acc <= '0;
                    r_q   <= b;
                    r_qm1 <= 1'b0;
                    r_cnt <= '0;
                end
                EXEC: begin
                    case (r_op)
                        2'b00: begin
                            result <= {{WIDTH{w_sum[WIDTH-1]}}, w_sum};
                            cout   <= w_add_c;
                            ovf    <= w_add_ovf;
                        end
                        2'b01: begin
                            result <= {{WIDTH{w_diff[WIDTH-1]}}, w_diff};
                            cout   <= w_sub_c;
                            ovf    <= w_sub_ovf;
                        end
                        default: begin
                            result <= '0;
                            cout   <= 1'b0;
                            ovf    <= 1'b0;
                        end
                    endcase
                end
                MUL: begin
                    r_acc <= w_acc_nxt;
                    r_q   <= w_q_nxt;
                    r_qm1 <= r_q[0];
                    r_cnt <= r_cnt + CW'(1);
                    if (w_last) begin
                        result <= {w_acc_nxt, w_q_nxt};
                        cout   <= 1'b0;
                        ovf    <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
